spi_bus_arbiter: RTL and testbench

//   Shares one SPI bus (sclk/mosi/CSn/miso) between N_REQ SPI master engines
//   (MAX7317 I/O expander, DAC, EEPROM, ...) on the QLA board. Grants the bus

---
 rtl/spi_bus_arbiter_if.sv | 26 ++
 rtl/spi_bus_arbiter.sv | 81 ++++++++
 tb/tb_spi_bus_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: bundles the requester-side and board-side SPI signals of the arbiter
interface spi_bus_arbiter_if #(
  parameter int N_REQ = 3
);
  localparam int OW = $clog2(N_REQ);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] other_busy;
  logic [N_REQ-1:0] req_sclk;
  logic [N_REQ-1:0] req_mosi;
  logic [N_REQ-1:0] req_csn;
  logic [N_REQ-1:0] timeout_err;
  logic [OW-1:0]    owner;
  logic             sclk;
  logic             mosi;
  logic             CSn;
  logic             clr_err;
  modport master (
    output req, req_sclk, req_mosi, req_csn, clr_err,
    input  grant, other_busy, sclk, mosi, CSn, owner, timeout_err
  );
  modport slave (
    input  req, req_sclk, req_mosi, req_csn, clr_err,
    output grant, other_busy, sclk, mosi, CSn, owner, timeout_err
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin owner of a shared SPI bus with CSn guard gap and hold watchdog
module spi_bus_arbiter #(
  parameter int N_REQ      = 3,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_HOLD   = 255
) (
  input logic              clk,
  input logic              rstn,
  spi_bus_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t           state;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] lockout;
  logic [N_REQ-1:0] timeout_err;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] tmo_vec;
  logic [OW-1:0]    owner;
  logic [OW-1:0]    sel;
  logic [OW-1:0]    j;
  logic [HW-1:0]    hold_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             tmo;
  assign eligible = bus.req & ~lockout;
  assign tmo      = state == GRANT && bus.req[owner] && hold_cnt == HW'(MAX_HOLD);
  assign tmo_vec  = tmo ? N_REQ'(1) << owner : '0;
  assign bus.grant       = grant;
  assign bus.other_busy  = ~grant;
  assign bus.owner       = owner;
  assign bus.timeout_err = timeout_err;
  assign bus.sclk        = |(bus.req_sclk & grant);
  assign bus.mosi        = |(bus.req_mosi & grant);
  assign bus.CSn         = ~|(~bus.req_csn & grant);
  // round-robin pick: scan from farthest to nearest after owner so the nearest eligible wins
  always_comb begin
    sel = owner;
    j   = owner;
    for (int k = N_REQ; k > 0; k--) begin
      j   = OW'((int'(owner) + k) % N_REQ);
      sel = eligible[j] ? j : sel;
    end
  end
  // arbitration FSM: grant, hold watchdog, guard gap, sticky errors and lockout
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= OW'(N_REQ - 1);
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      timeout_err <= '0;
      lockout     <= '0;
    end else begin
      lockout     <= (lockout & bus.req) | tmo_vec;
      timeout_err <= (bus.clr_err ? '0 : timeout_err) | tmo_vec;
      case (state)
        IDLE: if (|eligible) begin
          grant    <= N_REQ'(1) << sel;
          owner    <= sel;
          hold_cnt <= '0;
          state    <= GRANT;
        end
        GRANT: if (!bus.req[owner] || tmo) begin
          grant   <= '0;
          gap_cnt <= '0;
          state   <= GAP;
        end else begin
          hold_cnt <= hold_cnt == HW'(MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          state   <= gap_cnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: scoreboarded grant order plus direct checks of mux, gap, watchdog and reset
module tb_spi_bus_arbiter;
  localparam int N_REQ      = 3;
  localparam int GAP_CYCLES = 2;
  localparam int MAX_HOLD   = 255;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  logic [N_REQ-1:0] sb[$];
  logic [N_REQ-1:0] prev_grant = '0;
  spi_bus_arbiter_if #(.N_REQ(N_REQ)) bus ();
  spi_bus_arbiter #(.N_REQ(N_REQ), .GAP_CYCLES(GAP_CYCLES), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // every new grant must match the next expected owner in the scoreboard
  always @(negedge clk) begin
    if (rstn && bus.grant != 0 && prev_grant == 0) begin
      if (sb.size() == 0) check("sb_unexpected", bus.grant, 0);
      else check("sb_grant", bus.grant, sb.pop_front());
    end
    prev_grant = bus.grant;
  end
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.grant == 0 && n < 50);
    check("grant_wait", bus.grant != 0, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    int hold;
    bus.req = '0;
    bus.req_sclk = '0;
    bus.req_mosi = '0;
    bus.req_csn = '1;
    bus.clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", bus.grant, 0);
    check("rst_csn", bus.CSn, 1);
    check("rst_sclk", bus.sclk, 0);
    check("rst_owner", bus.owner, N_REQ - 1);
    check("rst_err", bus.timeout_err, 0);
    check("rst_busy", bus.other_busy, 3'b111);
    rstn = 1'b1;
    bus.req = 3'b001;
    bus.req_csn = 3'b110;
    bus.req_sclk = 3'b001;
    sb.push_back(3'b001);
    wait_grant(n);
    check("t1_latency", n, 1);
    check("t1_csn", bus.CSn, 0);
    check("t1_sclk", bus.sclk, 1);
    check("t1_busy", bus.other_busy, 3'b110);
    check("t1_owner", bus.owner, 0);
    bus.req_csn = 3'b111;
    #1 check("t1_csn_follow", bus.CSn, 1);
    bus.req_csn = 3'b110;
    bus.req = '0;
    for (int i = 0; i < GAP_CYCLES + 1; i++) begin
      @(negedge clk);
      check("t1_gap_grant", bus.grant, 0);
      check("t1_gap_csn", bus.CSn, 1);
    end
    bus.req_csn = '1;
    bus.req_sclk = '0;
    do_reset();
    bus.req = 3'b111;
    sb.push_back(3'b001);
    sb.push_back(3'b010);
    sb.push_back(3'b100);
    sb.push_back(3'b001);
    wait_grant(n);
    bus.req_sclk = 3'b100;
    bus.req_mosi = 3'b100;
    bus.req_csn = 3'b011;
    #1;
    check("t4_sclk_other", bus.sclk, 0);
    check("t4_mosi_other", bus.mosi, 0);
    check("t4_csn_other", bus.CSn, 1);
    bus.req_sclk = 3'b001;
    bus.req_mosi = 3'b001;
    bus.req_csn = 3'b110;
    #1;
    check("t4_sclk_own", bus.sclk, 1);
    check("t4_mosi_own", bus.mosi, 1);
    check("t4_csn_own", bus.CSn, 0);
    bus.req_sclk = '0;
    bus.req_mosi = '0;
    bus.req_csn = '1;
    for (int g = 0; g < 3; g++) begin
      logic [N_REQ-1:0] cur;
      cur = bus.grant;
      repeat (10) @(negedge clk);
      check("t2_held", bus.grant, cur);
      bus.req = 3'b111 & ~cur;
      @(negedge clk);
      check("t2_release", bus.grant, 0);
      bus.req = 3'b111;
      wait_grant(n);
      check("t2_gap", n, GAP_CYCLES + 1);
    end
    repeat (10) @(negedge clk);
    bus.req = '0;
    repeat (GAP_CYCLES + 2) @(negedge clk);
    bus.req = 3'b010;
    sb.push_back(3'b010);
    wait_grant(n);
    hold = 1;
    while (bus.grant[1] && hold < 400) begin
      @(negedge clk);
      if (bus.grant[1]) hold++;
    end
    check("t3_hold", hold, MAX_HOLD + 1);
    check("t3_err", bus.timeout_err, 3'b010);
    repeat (20) @(negedge clk);
    check("t3_locked", bus.grant, 0);
    check("t3_err_sticky", bus.timeout_err, 3'b010);
    bus.req = '0;
    @(negedge clk);
    bus.req = 3'b010;
    sb.push_back(3'b010);
    wait_grant(n);
    check("t3_regrant", bus.grant, 3'b010);
    bus.req = '0;
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    check("t3_clr", bus.timeout_err, 0);
    repeat (GAP_CYCLES + 2) @(negedge clk);
    bus.req = 3'b001;
    sb.push_back(3'b001);
    wait_grant(n);
    repeat (MAX_HOLD) @(negedge clk);
    check("t6_still", bus.grant, 3'b001);
    bus.req = '0;
    @(negedge clk);
    check("t6_release", bus.grant, 0);
    check("t6_no_err", bus.timeout_err, 0);
    repeat (GAP_CYCLES + 2) @(negedge clk);
    bus.req = 3'b100;
    sb.push_back(3'b100);
    wait_grant(n);
    bus.req_csn = 3'b011;
    bus.req_sclk = 3'b100;
    #1;
    check("t5_csn_before", bus.CSn, 0);
    check("t5_sclk_before", bus.sclk, 1);
    check("t5_owner_before", bus.owner, 2);
    @(negedge clk);
    rstn = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check("t5_grant", bus.grant, 0);
    check("t5_csn", bus.CSn, 1);
    check("t5_sclk", bus.sclk, 0);
    check("t5_owner", bus.owner, N_REQ - 1);
    check("t5_err", bus.timeout_err, 0);
    bus.req_csn = '1;
    bus.req_sclk = '0;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_left", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
